// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    localparam int CS_PER_MIN = 6000;
    localparam int BIN_W      = 16;

endpackage

// File: rtl/sw_tick_gen.sv
// Prescaler producing one tick every DIV enabled clocks; holds while disabled.
module sw_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign tick = en && (presc_q == LAST);

    // Holding while disabled keeps the partial interval across a pause.
    always_comb begin
        presc_d = presc_q;
        if (sync_clr) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch command FSM, centisecond counter, lap freeze and display register.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int MAX_COUNT = CS_PER_MIN - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_stop,
    input  logic             lap,
    input  logic             clear,
    output logic [BIN_W-1:0] bin,
    output logic             running,
    output logic             lap_active,
    output logic             wrap,
    output sw_state_t        state_dbg
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = $clog2(MAX_COUNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_COUNT);

    sw_state_t        state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    lap_q, lap_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             presc_en;
    logic             presc_clr;

    assign presc_en  = (state_q == RUN) || (state_q == LAP);
    assign presc_clr = clear || (state_q == IDLE);

    sw_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (presc_en),
        .sync_clr (presc_clr),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only the highest-priority command acts: clear, then start_stop, then lap.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (start_stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                LAP:     state_d = PAUSE;
                default: state_d = IDLE;
            endcase
        end else if (lap) begin
            case (state_q)
                RUN:     state_d = LAP;
                LAP:     state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        running    = (state_q == RUN) || (state_q == LAP);
        lap_active = (state_q == LAP);
        state_dbg  = state_q;
    end

    // Lap captures the pre-tick count; display follows next state so it has no extra latency.
    always_comb begin
        count_d = count_q;
        lap_d   = lap_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
            lap_d   = '0;
        end else begin
            if (tick) begin
                count_d = (count_q == CNT_MAX) ? '0 : count_q + CW'(1);
                wrap_d  = (count_q == CNT_MAX);
            end
            if (!start_stop && lap && (state_q == RUN)) begin
                lap_d = count_q;
            end
        end
        bin_d = (state_d == LAP) ? BIN_W'(lap_d) : BIN_W'(count_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            lap_q   <= '0;
            bin_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            lap_q   <= lap_d;
            bin_q   <= bin_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random commands against an elapsed-cycle model.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int MAX_COUNT = 5999;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             start_stop = 1'b0;
    logic             lap        = 1'b0;
    logic             clear      = 1'b0;
    logic [BIN_W-1:0] bin;
    logic             running;
    logic             lap_active;
    logic             wrap;
    sw_state_t        state_dbg;

    int checks   = 0;
    int errors   = 0;
    int wrap_cnt = 0;
    bit mon_en   = 1'b0;
    int b;

    // Reference: elapsed time is just the number of clocks spent counting, divided by DIV.
    int        m_cyc;
    int        m_lap;
    logic      m_wrap;
    sw_state_t m_state;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .bin        (bin),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap),
        .state_dbg  (state_dbg)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cs_of(input int cyc);
        return (cyc / DIV) % (MAX_COUNT + 1);
    endfunction

    function automatic bit is_active(input sw_state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= IDLE;
            m_cyc   <= 0;
            m_lap   <= 0;
            m_wrap  <= 1'b0;
        end else if (clear) begin
            m_state <= IDLE;
            m_cyc   <= 0;
            m_lap   <= 0;
            m_wrap  <= 1'b0;
        end else begin
            m_cyc  <= is_active(m_state) ? m_cyc + 1 : m_cyc;
            m_wrap <= is_active(m_state) && (((m_cyc + 1) % (DIV * (MAX_COUNT + 1))) == 0);
            if (start_stop) begin
                m_state <= is_active(m_state) ? PAUSE : RUN;
            end else if (lap && m_state == RUN) begin
                m_state <= LAP;
                m_lap   <= cs_of(m_cyc);
            end else if (lap && m_state == LAP) begin
                m_state <= RUN;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("mon_bin", int'(bin), (m_state == LAP) ? m_lap : cs_of(m_cyc));
            check_eq("mon_running", int'(running), int'(is_active(m_state)));
            check_eq("mon_lap_active", int'(lap_active), int'(m_state == LAP));
            check_eq("mon_wrap", int'(wrap), int'(m_wrap));
            check_eq("mon_state", int'(state_dbg), int'(m_state));
            if (wrap) wrap_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic ss, input logic lp, input logic cl);
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        @(negedge clk);
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic wait_bin(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (int'(bin) == target) break;
            @(negedge clk);
        end
        check_eq(tag, int'(bin), target);
    endtask

    initial begin
        rst_n = 1'b0;
        step(3);
        check_eq("rst_bin", int'(bin), 0);
        check_eq("rst_running", int'(running), 0);
        check_eq("rst_lap_active", int'(lap_active), 0);
        check_eq("rst_wrap", int'(wrap), 0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        step(1);

        // Ten ticks in 100 clocks from a fresh start.
        pulse(1'b1, 1'b0, 1'b0);
        step(100);
        check_eq("s1_bin", int'(bin), 10);
        check_eq("s1_running", int'(running), 1);
        check_eq("s1_no_wrap", wrap_cnt, 0);

        // Pause four clocks into an interval; resume keeps the partial interval.
        wait_bin(37, 400, "s2_reach37");
        step(3);
        pulse(1'b1, 1'b0, 1'b0);
        step(50);
        check_eq("s2_hold_bin", int'(bin), 37);
        check_eq("s2_paused", int'(running), 0);
        pulse(1'b1, 1'b0, 1'b0);
        step(5);
        check_eq("s2_pre_inc", int'(bin), 37);
        step(1);
        check_eq("s2_inc_at6", int'(bin), 38);

        // Lap freezes the display while counting continues.
        wait_bin(120, 1000, "s3_reach120");
        pulse(1'b0, 1'b1, 1'b0);
        step(300);
        check_eq("s3_frozen", int'(bin), 120);
        check_eq("s3_lap_on", int'(lap_active), 1);
        pulse(1'b0, 1'b1, 1'b0);
        check_eq("s3_live", int'(bin), 150);
        check_eq("s3_lap_off", int'(lap_active), 0);

        // All three commands together with a tick while in LAP: clear wins.
        b = int'(bin);
        for (int i = 0; i < 20; i++) begin
            if (int'(bin) != b) break;
            @(negedge clk);
        end
        check_eq("s5_sync", int'(bin), b + 1);
        pulse(1'b0, 1'b1, 1'b0);
        step(8);
        check_eq("s5_in_lap", int'(lap_active), 1);
        pulse(1'b1, 1'b1, 1'b1);
        check_eq("s5_bin", int'(bin), 0);
        check_eq("s5_running", int'(running), 0);
        check_eq("s5_lap_active", int'(lap_active), 0);
        check_eq("s5_state", int'(state_dbg), int'(IDLE));
        step(30);
        check_eq("s5_no_ticks", int'(bin), 0);

        // Asynchronous reset mid-interval, then a clean restart.
        pulse(1'b1, 1'b0, 1'b0);
        wait_bin(421, 5000, "s6_reach421");
        step(5);
        #2 rst_n = 1'b0;
        #1;
        check_eq("s6_async_bin", int'(bin), 0);
        check_eq("s6_async_running", int'(running), 0);
        check_eq("s6_async_lap", int'(lap_active), 0);
        check_eq("s6_async_wrap", int'(wrap), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        step(9);
        check_eq("s6_pre_tick", int'(bin), 0);
        step(1);
        check_eq("s6_first_tick", int'(bin), 1);

        // Random command traffic, checked every cycle by the monitor.
        pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r          = $urandom_range(0, 63);
            start_stop = (r < 4) || (r == 61) || (r == 62);
            lap        = ((r >= 4) && (r < 8)) || (r == 61) || (r == 62);
            clear      = (r == 62) || (r == 63);
            @(negedge clk);
        end
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;

        // Wrap from 5999 to 0 with a single-cycle wrap pulse.
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        wrap_cnt = 0;
        wait_bin(5998, 60100, "s4_reach5998");
        step(10);
        check_eq("s4_bin5999", int'(bin), 5999);
        check_eq("s4_wrap_low", int'(wrap), 0);
        step(10);
        check_eq("s4_bin0", int'(bin), 0);
        check_eq("s4_wrap_high", int'(wrap), 1);
        step(1);
        check_eq("s4_wrap_drop", int'(wrap), 0);
        check_eq("s4_wrap_count", wrap_cnt, 1);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
